// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: load-type codes, register-zero constant and the misalignment predicate
package mem_wb_stage_pkg;
  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4
  } load_type_e;
  localparam int unsigned REG_ZERO = 0;
  // Reserved load codes count as LW here too.
  function automatic logic misaligned(input logic [2:0] lt, input logic [1:0] ofs);
    logic half;
    half = (lt == LT_LH) || (lt == LT_LHU);
    return half ? ofs[0] : (lt == LT_LB || lt == LT_LBU) ? 1'b0 : (ofs != 2'd0);
  endfunction
endpackage

// File: rtl/mem_wb_stage_load_align.sv
// mem_wb_stage_load_align: big-endian byte/half extraction with sign or zero extension
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{~offset, 3'b000} +: 8];
    h = word[{~offset[1], 4'b0000} +: 16];
    data = load_type == LT_LB  ? {{(DATA_W-8){b[7]}}, b} :
           load_type == LT_LBU ? {{(DATA_W-8){1'b0}}, b} :
           load_type == LT_LH  ? {{(DATA_W-16){h[15]}}, h} :
           load_type == LT_LHU ? {{(DATA_W-16){1'b0}}, h} : word;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: writeback stage with stall-safe read-data hold and retired-instruction counter
// Optional: define MEM_WB_MISALIGN_CHECK_EN to suppress writeback of misaligned loads.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic                  MemToRegM,
  input  logic [2:0]            LoadTypeM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [DATA_W-1:0]     ALUOutM,
  input  logic [DATA_W-1:0]     RD,
  input  logic                  StallW,
  input  logic                  FlushW,
  output logic                  ValidW,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic [DATA_W-1:0]     ResultW,
  output logic [CNT_W-1:0]      InstRetW
);
  logic                  valid_q, regwrite_q, memtoreg_q, held_q, misalign;
  logic [2:0]            lt_q;
  logic [REG_ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0]     alu_q, hold_q, rd_eff, load_data;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      lt_q       <= 3'd0;
      wreg_q     <= '0;
      alu_q      <= '0;
      held_q     <= 1'b0;
      hold_q     <= '0;
      InstRetW   <= '0;
    end else begin
      if (FlushW || !StallW) begin
        valid_q    <= ValidM & ~FlushW;
        regwrite_q <= RegWriteM & ~FlushW;
      end
      if (!StallW) begin
        memtoreg_q <= MemToRegM;
        lt_q       <= LoadTypeM;
        wreg_q     <= WriteRegM;
        alu_q      <= ALUOutM;
      end
      // Memory RD moves on every clock; keep the value seen on the first stalled edge.
      if (FlushW || !StallW) held_q <= 1'b0;
      else if (!held_q) begin
        held_q <= 1'b1;
        hold_q <= RD;
      end
      if (valid_q && !StallW) InstRetW <= InstRetW + CNT_W'(1);
    end
  end
`ifdef MEM_WB_MISALIGN_CHECK_EN
  assign misalign = valid_q & memtoreg_q & misaligned(lt_q, alu_q[1:0]);
  always_ff @(posedge CLK)
    if (RST_N && !StallW && !FlushW && ValidM && MemToRegM && misaligned(LoadTypeM, ALUOutM[1:0]))
      $display("Misaligned load at address %h", ALUOutM);
`else
  assign misalign = 1'b0;
`endif
  assign rd_eff = held_q ? hold_q : RD;
  mem_wb_stage_load_align #(.DATA_W(DATA_W)) u_align (
    .word      (rd_eff),
    .offset    (alu_q[1:0]),
    .load_type (lt_q),
    .data      (load_data)
  );
  assign ValidW    = valid_q;
  assign RegWriteW = valid_q & regwrite_q & (wreg_q != REG_ADDR_W'(REG_ZERO)) & ~misalign;
  assign WriteRegW = wreg_q;
  assign ResultW   = memtoreg_q ? load_data : alu_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors with hand-computed expectations for mem_wb_stage
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        ValidM = 0, RegWriteM = 0, MemToRegM = 0, StallW = 0, FlushW = 0;
  logic [2:0]  LoadTypeM = 3'd0;
  logic [4:0]  WriteRegM = 5'd0;
  logic [31:0] ALUOutM = 32'd0, RD = 32'd0;
  logic        ValidW, RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW, InstRetW;
  int          errors = 0, checks = 0, exp_ret = 0;
  bit          m_valid = 0;

  mem_wb_stage dut (
    .CLK(CLK), .RST_N(RST_N), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
    .LoadTypeM(LoadTypeM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .RD(RD),
    .StallW(StallW), .FlushW(FlushW), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .WriteRegW(WriteRegW), .ResultW(ResultW), .InstRetW(InstRetW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected retire count: a valid W instruction leaves on any unstalled edge.
  task automatic step();
    @(posedge CLK);
    if (m_valid && !StallW) exp_ret++;
    if (FlushW) m_valid = 0;
    else if (!StallW) m_valid = ValidM;
    #1;
  endtask

  task automatic issue(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [4:0] wreg, input logic [31:0] alu);
    ValidM = v; RegWriteM = rw; MemToRegM = m2r; LoadTypeM = lt; WriteRegM = wreg; ALUOutM = alu;
    step();
    ValidM = 0; RegWriteM = 0; MemToRegM = 0;
  endtask

  task automatic load(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                      input logic [31:0] rd, input logic [31:0] exp);
    issue(1, 1, 1, lt, 5'd3, addr);
    RD = rd;
    #1;
    check(tag, ResultW, exp);
    check({tag, "_ret"}, InstRetW, exp_ret);
  endtask

  initial begin
    #12;
    check("rst_valid", ValidW, 0);
    check("rst_rw", RegWriteW, 0);
    check("rst_wreg", WriteRegW, 0);
    check("rst_result", ResultW, 0);
    check("rst_ret", InstRetW, 0);
    RST_N = 1;
    issue(1, 1, 1, LT_LW, 5'd8, 32'h404);
    RD = 32'hDEADBEEF;
    #1;
    check("lw_valid", ValidW, 1);
    check("lw_rw", RegWriteW, 1);
    check("lw_wreg", WriteRegW, 8);
    check("lw_result", ResultW, 32'hDEADBEEF);
    check("lw_ret0", InstRetW, 0);
    load("lb0", LT_LB, 32'h1000, 32'h80FF7F01, 32'hFFFFFF80);
    check("lb0_ret1", InstRetW, 1);
    load("lbu0", LT_LBU, 32'h1000, 32'h80FF7F01, 32'h00000080);
    load("lb2", LT_LB, 32'h1002, 32'h80FF7F01, 32'h0000007F);
    load("lbu3", LT_LBU, 32'h1003, 32'h80FF7F01, 32'h00000001);
    load("lb1", LT_LB, 32'h1001, 32'h80FF7F01, 32'hFFFFFFFF);
    load("lh2", LT_LH, 32'h1002, 32'h80FF7F01, 32'h00007F01);
    load("lh0", LT_LH, 32'h1000, 32'h80FF7F01, 32'hFFFF80FF);
    load("lhu0", LT_LHU, 32'h1000, 32'h80FF7F01, 32'h000080FF);
    load("rsvd7", 3'd7, 32'h1000, 32'h80FF7F01, 32'h80FF7F01);
    load("lw406", LT_LW, 32'h406, 32'hCAFEF00D, 32'hCAFEF00D);
`ifdef MEM_WB_MISALIGN_CHECK_EN
    check("lw406_rw", RegWriteW, 0);
`else
    check("lw406_rw", RegWriteW, 1);
`endif
    load("st_load", LT_LW, 32'h200, 32'h12345678, 32'h12345678);
    StallW = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      RD = 32'hAAAAAAAA ^ i;
      #1;
      check("st_result", ResultW, 32'h12345678);
      check("st_ret", InstRetW, exp_ret);
      check("st_valid", ValidW, 1);
    end
    StallW = 0;
    step();
    check("st_release_ret", InstRetW, exp_ret);
    check("st_release_valid", ValidW, 0);
    issue(1, 1, 0, LT_LW, 5'd10, 32'h55);
    check("alu_result", ResultW, 32'h55);
    check("alu_rw", RegWriteW, 1);
    FlushW = 1; StallW = 1;
    step();
    check("fl_valid", ValidW, 0);
    check("fl_rw", RegWriteW, 0);
    check("fl_ret", InstRetW, exp_ret);
    FlushW = 0; StallW = 0;
    issue(1, 1, 0, LT_LW, 5'd0, 32'h77);
    check("r0_valid", ValidW, 1);
    check("r0_rw", RegWriteW, 0);
    check("r0_result", ResultW, 32'h77);
    issue(1, 1, 1, LT_LW, 5'd4, 32'h300);
    RD = 32'h0BADF00D;
    #1;
    check("pre_rst_valid", ValidW, 1);
    check("pre_rst_ret", InstRetW, exp_ret);
    RST_N = 0;
    #1;
    check("arst_valid", ValidW, 0);
    check("arst_rw", RegWriteW, 0);
    check("arst_wreg", WriteRegW, 0);
    check("arst_result", ResultW, 0);
    check("arst_ret", InstRetW, 0);
    m_valid = 0; exp_ret = 0;
    @(negedge CLK);
    RST_N = 1;
    issue(1, 1, 1, LT_LBU, 5'd6, 32'h2);
    RD = 32'h11223344;
    #1;
    check("post_rst_result", ResultW, 32'h33);
    step();
    check("post_rst_ret", InstRetW, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Writeback stage directly downstream of the data Memory block; pairs registered memory read data (valid one cycle after address) with the M-stage control captured that same cycle.
- Performs MIPS big-endian load extraction/extension, selects ALU result vs load data, and drives the register-file write port.
- Holds state across W-stage stalls: memory RD keeps changing every clock, so a hold register preserves the first valid RD.
- Maintains a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- ValidM  in  1  M-stage slot holds a real instruction.
- RegWriteM  in  1  instruction writes a register.
- MemToRegM  in  1  result comes from memory.
- LoadTypeM  in  3  load width/sign code (package enum).
- WriteRegM  in  REG_ADDR_W  destination register.
- ALUOutM  in  DATA_W  ALU result / memory byte address.
- RD  in  DATA_W  Memory read data; valid the cycle after ALUOutM is presented.
- StallW  in  1  hold W stage.
- FlushW  in  1  kill the instruction entering W.
- ValidW  out  1  W slot valid.
- RegWriteW  out  1  register-file write enable.
- WriteRegW  out  REG_ADDR_W  register-file write address.
- ResultW  out  DATA_W  register-file write data.
- InstRetW  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (RST_N=0, async): ValidW=0, RegWriteW=0, WriteRegW=0, ResultW=0, InstRetW=0; hold register and held flag cleared. Reset mid-stall discards the held instruction.
- W register: on posedge with StallW=0, capture ValidM, RegWriteM, MemToRegM, LoadTypeM, WriteRegM, ALUOutM[DATA_W-1:0]. With StallW=1, hold.
- Flush priority: FlushW=1 takes priority over StallW. Next posedge sets valid=0 and regwrite=0; other fields are don't-care.
- RD hold: on the first stalled posedge (StallW=1, held=0), latch RD into hold_q and set held=1. Effective read data = held ? hold_q : RD. held clears on the first posedge with StallW=0.
- Load extraction: offset = captured ALUOutM[1:0], big-endian.
  - LB/LBU: offset 0 selects bits 31:24; 1 selects 23:16; 2 selects 15:8; 3 selects 7:0.
  - LH/LHU: offset[1]=0 selects 31:16; 1 selects 15:0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Reserved codes behave as LW.
  - A `undefined word from memory propagates unchanged through LW.
- Result: ResultW = MemToReg ? extracted : ALUOut. Combinational from the W register and the effective read data, so memory latency is exactly 1 cycle.
- RegWriteW = valid & regwrite & (WriteRegW != 0). Writes to $0 are always suppressed.
- InstRetW increments by 1 on each posedge where valid=1 and StallW=0 (instruction leaving W). It wraps modulo 2^CNT_W.
- Simultaneous flush+stall: the instruction is killed, held clears, and the counter does not increment.

Optional Feature:
- Macro: MEM_WB_MISALIGN_CHECK_EN.
- Defined: a valid load with LW and offset!=0, or LH/LHU with offset[0]=1, forces RegWriteW=0. It also issues $display("Misaligned load at address %h", addr) once per instruction, the cycle it first enters W. Such an instruction still counts as retired.
- Undefined: no check; extraction uses the offset bits as specified and writeback proceeds.

Decomposition:
- Shared package/header (alongside mips.h):
  - LoadType enum: LT_LW=0, LT_LH=1, LT_LHU=2, LT_LB=3, LT_LBU=4.
  - Register-zero constant.
  - Reuse of the existing `undefined.
- One natural sub-module: load_align, purely combinational (word, offset, load type -> extended data), so it can be unit-tested exhaustively.

Test Plan:
- Reset mid-stream: assert RST_N=0 while ValidW=1 -> all outputs 0 immediately (async), InstRetW=0.
- LW, ALUOutM=0x404, RD=0xDEADBEEF next cycle, WriteRegM=8 -> RegWriteW=1, WriteRegW=8, ResultW=0xDEADBEEF, InstRetW increments.
- Byte/half extraction with RD=0x80FF7F01:
  - LB offset 0 -> 0xFFFFFF80.
  - LBU offset 0 -> 0x00000080.
  - LB offset 2 -> 0x0000007F.
  - LH offset 2 -> 0x00007F01.
  - LHU offset 0 -> 0x000080FF.
- Stall hold: load captured, RD=0x12345678, StallW=1 for 3 cycles while RD changes to 0xAAAAAAAA -> ResultW stays 0x12345678 and InstRetW unchanged until release, then increments by 1.
- Flush vs stall: FlushW=1 and StallW=1 on the same edge -> ValidW=0, RegWriteW=0, counter unchanged. Separately, ALU op with WriteRegM=0 -> RegWriteW=0.
- With MEM_WB_MISALIGN_CHECK_EN: LW at 0x406 -> RegWriteW=0, exactly one $display. Without the macro -> RegWriteW=1.
